serial_shift_sequencer: RTL and testbench

- Multi-cycle sequencer for the ALU shift path (SLL/SRL/SRA, register and immediate forms).
- Computes shifts iteratively, SHIFT_STEP bits per cycle, instead of with a full barrel shifter.
- Sits beside the ALU in EX. The decoded ALU op select and the operands start a job. Pipeline stall is held until the result is ready.
- Non-shift ops never enter the block.

---
 rtl/serial_shift_sequencer.sv | 159 +++++++++++++++
 tb/tb_serial_shift_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_sequencer.sv
// ============================================================================
// serial_shift_sequencer
// Iterative SLL/SRL/SRA unit beside the EX-stage ALU; stalls the pipeline
// while a shift of up to 31 bits completes SHIFT_STEP bits per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef kALU_OP_SEL_WIDTH
`define kALU_OP_SEL_WIDTH 4
`endif
`ifndef kSAIL_ALUCTL_ADD
`define kSAIL_ALUCTL_ADD 4'h0
`endif
`ifndef kSAIL_ALUCTL_SLL
`define kSAIL_ALUCTL_SLL 4'h1
`endif
`ifndef kSAIL_ALUCTL_SRL
`define kSAIL_ALUCTL_SRL 4'h5
`endif
`ifndef kSAIL_ALUCTL_SRA
`define kSAIL_ALUCTL_SRA 4'hD
`endif

module serial_shift_sequencer #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [`kALU_OP_SEL_WIDTH-1:0] op_sel_i,
  input  logic [XLEN-1:0]               operand_i,
  input  logic [4:0]                    shamt_i,
  input  logic                          flush_i,
  output logic                          stall_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [XLEN-1:0]               result_o,
  output logic                          err_o
);

  if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 && SHIFT_STEP != 8) begin : g_bad_step
    $error("serial_shift_sequencer: SHIFT_STEP must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [5:0] c_STEP = 6'(SHIFT_STEP);

  state_t                        r_state;
  state_t                        w_next_state;
  logic [`kALU_OP_SEL_WIDTH-1:0] r_op;
  logic [5:0]                    r_rem;
  logic [XLEN-1:0]               r_data;
  logic [XLEN-1:0]               r_result;
  logic                          r_err;

  logic                          w_is_shift;
  logic                          w_can_start;
  logic                          w_accept;
  logic                          w_reject;
  logic [5:0]                    w_step;
  logic [5:0]                    w_rem_next;
  logic [XLEN-1:0]               w_shifted;

  assign w_is_shift = (op_sel_i == `kSAIL_ALUCTL_SLL) ||
                      (op_sel_i == `kSAIL_ALUCTL_SRL) ||
                      (op_sel_i == `kSAIL_ALUCTL_SRA);
  // Gating with rst_i keeps stall_o low while reset is held.
  assign w_can_start = start_i && !flush_i && !rst_i && (r_state != S_SHIFT);
  assign w_accept    = w_can_start && w_is_shift;
  assign w_reject    = w_can_start && !w_is_shift;

  assign w_step     = (r_rem < c_STEP) ? r_rem : c_STEP;
  assign w_rem_next = r_rem - w_step;

  always_comb begin
    w_shifted = r_data;
    case (r_op)
      `kSAIL_ALUCTL_SLL: w_shifted = r_data << w_step;
      `kSAIL_ALUCTL_SRL: w_shifted = r_data >> w_step;
      `kSAIL_ALUCTL_SRA: w_shifted = $unsigned($signed(r_data) >>> w_step);
      default:           w_shifted = r_data;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (shamt_i == 5'd0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (w_rem_next == 6'd0) w_next_state = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (w_accept) begin
          busy_o       = 1'b1;
          w_next_state = (shamt_i == 5'd0) ? S_DONE : S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_accept) stall_o = 1'b1;
    if (flush_i)  w_next_state = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_rem    <= '0;
      r_data   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_data <= operand_i;
        r_op   <= op_sel_i;
        r_rem  <= {1'b0, shamt_i};
      end else if (r_state == S_SHIFT) begin
        r_data <= w_shifted;
        r_rem  <= w_rem_next;
      end
      // A zero-amount job enters DONE straight from the captured operand.
      if (w_next_state == S_DONE) r_result <= w_accept ? operand_i : w_shifted;
    end
  end

  assign result_o = r_result;
  assign err_o    = r_err;

  a_no_start_in_shift : assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_state == S_SHIFT && start_i));

endmodule

`default_nettype wire

// File: tb/tb_serial_shift_sequencer.sv
// ============================================================================
// tb_serial_shift_sequencer
// Directed vector bench for serial_shift_sequencer at SHIFT_STEP 1, 4 and 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef kALU_OP_SEL_WIDTH
`define kALU_OP_SEL_WIDTH 4
`endif
`ifndef kSAIL_ALUCTL_ADD
`define kSAIL_ALUCTL_ADD 4'h0
`endif
`ifndef kSAIL_ALUCTL_SLL
`define kSAIL_ALUCTL_SLL 4'h1
`endif
`ifndef kSAIL_ALUCTL_SRL
`define kSAIL_ALUCTL_SRL 4'h5
`endif
`ifndef kSAIL_ALUCTL_SRA
`define kSAIL_ALUCTL_SRA 4'hD
`endif

module tb_serial_shift_sequencer;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [`kALU_OP_SEL_WIDTH-1:0] op;
  logic [31:0]                   operand;
  logic [4:0]                    shamt;
  logic                          flush;
  logic [2:0]                    stall_w, busy_w, done_w, err_w;
  logic [31:0]                   res_w [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_shift_sequencer #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_sel_i(op), .operand_i(operand),
    .shamt_i(shamt), .flush_i(flush), .stall_o(stall_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .result_o(res_w[0]), .err_o(err_w[0]));
  serial_shift_sequencer #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_sel_i(op), .operand_i(operand),
    .shamt_i(shamt), .flush_i(flush), .stall_o(stall_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .result_o(res_w[1]), .err_o(err_w[1]));
  serial_shift_sequencer #(.XLEN(32), .SHIFT_STEP(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_sel_i(op), .operand_i(operand),
    .shamt_i(shamt), .flush_i(flush), .stall_o(stall_w[2]), .busy_o(busy_w[2]),
    .done_o(done_w[2]), .result_o(res_w[2]), .err_o(err_w[2]));

  typedef struct {
    logic [`kALU_OP_SEL_WIDTH-1:0] op;
    logic [31:0]                   operand;
    logic [4:0]                    shamt;
    logic [31:0]                   exp;
  } vec_t;

  vec_t vecs [12];
  int   steps [3] = '{1, 4, 8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int          lat [3];
    int          ndone [3];
    int          nstall [3];
    logic [31:0] got [3];
    logic [31:0] prev1;
    logic        inter_bad;
    prev1     = res_w[0];
    inter_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; op = v.op; operand = v.operand; shamt = v.shamt;
    #1;
    chk($sformatf("v%0d req_stall", idx), {29'd0, stall_w}, 32'd7);
    chk($sformatf("v%0d req_busy", idx), {29'd0, busy_w}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; ndone[k] = 0; nstall[k] = 0; got[k] = '0;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (stall_w[k]) nstall[k]++;
        if (done_w[k]) begin
          ndone[k]++;
          if (lat[k] == 0) begin
            lat[k] = c;
            got[k] = res_w[k];
          end
        end
      end
      if (lat[0] == 0 && res_w[0] !== prev1) inter_bad = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("v%0d s%0d latency", idx, steps[k]), lat[k], 1 + ceil_div(v.shamt, steps[k]));
      chk($sformatf("v%0d s%0d result", idx, steps[k]), got[k], v.exp);
      chk($sformatf("v%0d s%0d done_pulses", idx, steps[k]), ndone[k], 1);
      chk($sformatf("v%0d s%0d stall_cycles", idx, steps[k]), nstall[k], ceil_div(v.shamt, steps[k]));
      chk($sformatf("v%0d s%0d result_hold", idx, steps[k]), res_w[k], v.exp);
    end
    chk($sformatf("v%0d no_intermediate", idx), {31'd0, inter_bad}, 32'd0);
  endtask

  initial begin
    logic [31:0] held [3];
    int          nd;

    vecs[0]  = '{`kSAIL_ALUCTL_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{`kSAIL_ALUCTL_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[2]  = '{`kSAIL_ALUCTL_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[3]  = '{`kSAIL_ALUCTL_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{`kSAIL_ALUCTL_SLL, 32'h0000_0001, 5'd5,  32'h0000_0020};
    vecs[5]  = '{`kSAIL_ALUCTL_SRA, 32'h7FFF_0000, 5'd31, 32'h0000_0000};
    vecs[6]  = '{`kSAIL_ALUCTL_SRA, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
    vecs[7]  = '{`kSAIL_ALUCTL_SRL, 32'hF000_0000, 5'd28, 32'h0000_000F};
    vecs[8]  = '{`kSAIL_ALUCTL_SLL, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};
    vecs[9]  = '{`kSAIL_ALUCTL_SRA, 32'hC000_0000, 5'd9,  32'hFFE0_0000};
    vecs[10] = '{`kSAIL_ALUCTL_SRL, 32'h1234_5678, 5'd3,  32'h0246_8ACF};
    vecs[11] = '{`kSAIL_ALUCTL_SLL, 32'h1234_5678, 5'd7,  32'h1A2B_3C00};

    rst = 1'b1; start = 1'b1; op = `kSAIL_ALUCTL_SLL; operand = 32'hFFFF_FFFF;
    shamt = 5'd3; flush = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst s%0d result", steps[k]), res_w[k], 32'd0);
      chk($sformatf("rst s%0d flags", steps[k]),
          {28'd0, stall_w[k], busy_w[k], done_w[k], err_w[k]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Back-to-back: zero-shift job, then a new job accepted in its DONE cycle.
    @(negedge clk);
    start = 1'b1; op = `kSAIL_ALUCTL_SRL; operand = 32'hDEAD_BEEF; shamt = 5'd0;
    @(posedge clk);
    #1 op = `kSAIL_ALUCTL_SLL; operand = 32'h0000_0001; shamt = 5'd1;
    @(negedge clk);
    chk("b2b done1", {29'd0, done_w}, 32'd7);
    chk("b2b result1", res_w[0], 32'hDEAD_BEEF);
    chk("b2b stall_in_done", {29'd0, stall_w}, 32'd7);
    chk("b2b busy_in_done", {29'd0, busy_w}, 32'd7);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b shift_nodone", {29'd0, done_w}, 32'd0);
    chk("b2b shift_busy", {29'd0, busy_w}, 32'd7);
    @(negedge clk);
    chk("b2b done2", {29'd0, done_w}, 32'd7);
    for (int k = 0; k < 3; k++) chk($sformatf("b2b s%0d result2", steps[k]), res_w[k], 32'h0000_0002);
    @(negedge clk);
    chk("b2b idle", {29'd0, busy_w | done_w}, 32'd0);

    // Flush during the third SHIFT cycle of a 20-bit shift.
    for (int k = 0; k < 3; k++) held[k] = res_w[k];
    @(negedge clk);
    start = 1'b1; op = `kSAIL_ALUCTL_SLL; operand = 32'h0000_0003; shamt = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush busy_before", {29'd0, busy_w}, 32'd7);
    @(posedge clk);
    #1 flush = 1'b0;
    nd = 0;
    @(negedge clk);
    chk("flush idle_busy", {29'd0, busy_w}, 32'd0);
    chk("flush idle_stall", {29'd0, stall_w}, 32'd0);
    for (int c = 0; c < 30; c++) begin
      if (done_w != 3'b000) nd++;
      @(negedge clk);
    end
    chk("flush no_done", nd, 0);
    for (int k = 0; k < 3; k++) chk($sformatf("flush s%0d result_kept", steps[k]), res_w[k], held[k]);

    // start_i together with flush_i: nothing captured.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = `kSAIL_ALUCTL_SRL; operand = 32'h1111_1111; shamt = 5'd2;
    #1 chk("sf stall", {29'd0, stall_w}, 32'd0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ((done_w | busy_w) != 3'b000) nd++;
    end
    chk("sf no_job", nd, 0);
    chk("sf result_kept", res_w[0], held[0]);

    // Non-shift op raises err_o the following cycle only.
    @(negedge clk);
    start = 1'b1; op = `kSAIL_ALUCTL_ADD; operand = 32'h0000_00FF; shamt = 5'd4;
    #1 chk("err stall", {29'd0, stall_w}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("err pulse", {29'd0, err_w}, 32'd7);
    chk("err idle", {29'd0, busy_w | done_w}, 32'd0);
    @(negedge clk);
    chk("err one_cycle", {29'd0, err_w}, 32'd0);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    start = 1'b1; op = `kSAIL_ALUCTL_SLL; operand = 32'h0000_0001; shamt = 5'd31;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst flags", {29'd0, stall_w | busy_w | done_w}, 32'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("arst s%0d result", steps[k]), res_w[k], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if ((done_w | busy_w) != 3'b000) nd++;
    end
    chk("arst no_done", nd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
